// File: rtl/cf_math_pkg.sv
// Small math helpers shared by arbiter and counter logic.
package cf_math_pkg;

  // Index width for n items; a single item still needs one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/iopmp_arb_pkg.sv
// Arbitration helpers for IOPMP checker ports.
package iopmp_arb_pkg;

  // Rotate a priority pointer past idx with an explicit wrap at n.
  function automatic int unsigned next_prio(input int unsigned idx, input int unsigned n);
    return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros, MODE=1 leading zeros.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    if (MODE == 1'b0) begin
      // Scan downwards so the lowest set bit wins.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/iopmp_rr_arbiter.sv
// Round-robin arbiter sharing one IOPMP checker port, with a one-entry
// registered output stage.
module iopmp_rr_arbiter
  import iopmp_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = cf_math_pkg::idx_width(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [DataWidth-1:0]             data_o,
  output logic [IdxWidth-1:0]              idx_o
);

  logic [IdxWidth-1:0]  prio_q;
  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic [IdxWidth-1:0]  idx_q;

  logic [NumReq-1:0]    mask;
  logic [NumReq-1:0]    masked;
  logic [IdxWidth-1:0]  sel_masked;
  logic [IdxWidth-1:0]  sel_raw;
  logic                 masked_empty;
  logic                 raw_empty;
  logic [IdxWidth-1:0]  sel;
  logic                 any;
  logic                 load;
  logic [DataWidth-1:0] sel_data;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      mask[i] = (i >= 32'(prio_q));
    end
  end

  assign masked = req_valid_i & mask;

  lzc #(
    .WIDTH     (NumReq),
    .MODE      (1'b0),
    .CNT_WIDTH (IdxWidth)
  ) u_lzc_masked (
    .in_i    (masked),
    .cnt_o   (sel_masked),
    .empty_o (masked_empty)
  );

  lzc #(
    .WIDTH     (NumReq),
    .MODE      (1'b0),
    .CNT_WIDTH (IdxWidth)
  ) u_lzc_raw (
    .in_i    (req_valid_i),
    .cnt_o   (sel_raw),
    .empty_o (raw_empty)
  );

  // Requesters at or above the pointer go first; otherwise wrap to the lowest.
  assign sel  = masked_empty ? sel_raw : sel_masked;
  assign any  = ~raw_empty;
  assign load = any & (~valid_q | ready_i) & ~flush_i;

  always_comb begin
    req_ready_o = '0;
    sel_data    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (sel == IdxWidth'(i)) begin
        req_ready_o[i] = load;
        sel_data       = req_data_i[i];
      end
    end
  end

  // Output stage: flush drops the beat and rewinds the pointer but keeps payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      prio_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
        prio_q  <= '0;
      end else if (load) begin
        valid_q <= 1'b1;
        prio_q  <= IdxWidth'(next_prio(32'(sel), NumReq));
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      if (load) begin
        data_q <= sel_data;
        idx_q  <= sel;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

endmodule

// File: tb/tb_iopmp_rr_arbiter.sv
// Directed bench for iopmp_rr_arbiter: a 4-requester and a 3-requester instance.
module tb_iopmp_rr_arbiter;

  logic             clk;
  logic             rst_n;

  logic             flush4;
  logic [3:0]       req_valid4;
  logic [3:0]       req_ready4;
  logic [3:0][31:0] req_data4;
  logic             valid4;
  logic             ready4;
  logic [31:0]      data4;
  logic [1:0]       idx4;

  logic             flush3;
  logic [2:0]       req_valid3;
  logic [2:0]       req_ready3;
  logic [2:0][31:0] req_data3;
  logic             valid3;
  logic             ready3;
  logic [31:0]      data3;
  logic [1:0]       idx3;

  int n_checks;
  int n_errors;

  iopmp_rr_arbiter dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush4),
    .req_valid_i (req_valid4),
    .req_ready_o (req_ready4),
    .req_data_i  (req_data4),
    .valid_o     (valid4),
    .ready_i     (ready4),
    .data_o      (data4),
    .idx_o       (idx4)
  );

  iopmp_rr_arbiter #(.NumReq(3)) dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush3),
    .req_valid_i (req_valid3),
    .req_ready_o (req_ready3),
    .req_data_i  (req_data3),
    .valid_o     (valid3),
    .ready_i     (ready3),
    .data_o      (data3),
    .idx_o       (idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_rdy4 [5];
  logic [2:0] exp_rdy3 [4];
  logic [1:0] exp_idx3 [4];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    flush4     = 1'b0;
    req_valid4 = '0;
    ready4     = 1'b0;
    flush3     = 1'b0;
    req_valid3 = '0;
    ready3     = 1'b0;
    for (int i = 0; i < 4; i++) req_data4[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) req_data3[i] = 32'hC000_0000 + 32'(i);
    exp_rdy4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rdy3 = '{3'b001, 3'b100, 3'b001, 3'b100};
    exp_idx3 = '{2'd0, 2'd0, 2'd2, 2'd0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_valid", 64'(valid4), 64'd0);
      check("idle_ready", 64'(req_ready4), 64'd0);
      check("idle_idx", 64'(idx4), 64'd0);
      check("idle_data", 64'(data4), 64'd0);
    end

    // All requesting with ready high: one grant per cycle in rotation
    next_cycle();
    req_valid4 = 4'b1111;
    ready4     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_ready", 64'(req_ready4), 64'(exp_rdy4[k]));
      if (k == 0) begin
        check("rr_valid0", 64'(valid4), 64'd0);
      end else begin
        check("rr_valid", 64'(valid4), 64'd1);
        check("rr_idx", 64'(idx4), 64'(k - 1));
        check("rr_data", 64'(data4), 64'(32'h1000_0000 + 32'(k - 1)));
      end
      next_cycle();
    end
    check("rr_idx_last", 64'(idx4), 64'd0);

    // Capture requester 1, then hold under back-pressure
    req_valid4   = 4'b0010;
    req_data4[1] = 32'hA5A5_0001;
    @(negedge clk);
    check("bp_grant1", 64'(req_ready4), 64'b0010);
    next_cycle();
    ready4     = 1'b0;
    req_valid4 = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", 64'(valid4), 64'd1);
      check("bp_data", 64'(data4), 64'hA5A5_0001);
      check("bp_idx", 64'(idx4), 64'd1);
      check("bp_ready", 64'(req_ready4), 64'd0);
      next_cycle();
    end
    ready4 = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(req_ready4), 64'b0100);
    next_cycle();

    // Flush with prio at 3 and a beat pending; flush also beats ready
    check("fl_idx_pre", 64'(idx4), 64'd2);
    flush4 = 1'b1;
    @(negedge clk);
    check("fl_valid_pre", 64'(valid4), 64'd1);
    check("fl_no_grant", 64'(req_ready4), 64'd0);
    next_cycle();
    flush4     = 1'b0;
    ready4     = 1'b0;
    req_valid4 = 4'b1001;
    @(negedge clk);
    check("fl_valid", 64'(valid4), 64'd0);
    check("fl_idx_hold", 64'(idx4), 64'd2);
    check("fl_prio0", 64'(req_ready4), 64'b0001);
    next_cycle();
    req_valid4 = 4'b0000;

    // Asynchronous reset mid-cycle
    check("ar_valid_pre", 64'(valid4), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(valid4), 64'd0);
    check("ar_data", 64'(data4), 64'd0);
    next_cycle();
    rst_n      = 1'b1;
    req_valid4 = 4'b1111;
    ready4     = 1'b1;
    @(negedge clk);
    check("ar_prio0", 64'(req_ready4), 64'b0001);
    next_cycle();
    req_valid4 = 4'b0000;

    // Three requesters, non-power-of-two wrap
    req_valid3 = 3'b101;
    ready3     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("n3_ready", 64'(req_ready3), 64'(exp_rdy3[k]));
      if (k > 0) begin
        check("n3_idx", 64'(idx3), 64'(exp_idx3[k]));
        check("n3_data", 64'(data3), 64'(32'hC000_0000 + 32'(exp_idx3[k])));
      end
      next_cycle();
    end
    check("n3_idx_last", 64'(idx3), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iopmp_rr_arbiter.md
# iopmp_rr_arbiter

Round-robin arbiter with a one-entry registered output stage. It shares one downstream IOPMP checker port among `NumReq` requesters (bus initiators / DMA channels). Selection uses two `lzc` trailing-zero counters, one on the rotated-masked request vector and one on the raw request vector. Fairness comes from a rotating priority pointer that moves past each granted requester.

## Interface
- `NumReq`, default 4: number of requesters, ≥1; non-power-of-two is supported.
- `DataWidth`, default 32: payload width per requester.
- `IdxWidth`, default `cf_math_pkg::idx_width(NumReq)`: dependent, do not override.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of output stage and priority pointer.
- `req_valid_i`  in  NumReq  per-requester valid.
- `req_ready_o`  out  NumReq  per-requester grant; at most one bit set.
- `req_data_i`  in  NumReq×DataWidth  per-requester payload.
- `valid_o`  out  1  output beat valid (registered).
- `ready_i`  in  1  downstream accept.
- `data_o`  out  DataWidth  registered payload.
- `idx_o`  out  IdxWidth  index of the requester that produced `data_o`.

## Operation
- State:
  - `prio_q` (IdxWidth): highest-priority requester index.
  - Output register `{valid_q, data_q, idx_q}`.
- Masked vector: `mask[i] = (i >= prio_q)`; `masked = req_valid_i & mask`.
- Selection:
  - If `|masked`, `sel` = trailing-zero count of `masked`.
  - Otherwise `sel` = trailing-zero count of `req_valid_i`.
  - `any = |req_valid_i`.
- Capture enable: `load = any & (~valid_q | ready_i) & ~flush_i`.
- `req_ready_o[sel] = load`; all other bits 0. Ready depends combinationally on `req_valid_i` and `ready_i`; there is no combinational valid→valid path to the output.
- On `load`:
  - `data_q <= req_data_i[sel]`, `idx_q <= sel`, `valid_q <= 1`.
  - `prio_q <= (sel == NumReq-1) ? 0 : sel+1` (explicit wrap; no modulo-2^n wrap).
- Drain: when `valid_q & ready_i & ~load`, set `valid_q <= 0`.
- `flush_i` has priority over everything:
  - `valid_q <= 0`, `prio_q <= 0`, no grant that cycle.
  - `data_q`/`idx_q` hold their values.
- Once `valid_q` is set, `data_o`/`idx_o` are stable until the handshake.
- `NumReq == 1`: `prio_q` stays 0, `sel` is 0, behaves as a one-entry register slice.
- Requesters must hold valid/data until `req_ready_o`. The arbiter may grant a different requester than the previous cycle if the pointer moved; no grant lock is needed because the grant and capture happen in the same cycle.

## Timing
- Reset values: `valid_o` 0, `data_o` 0, `idx_o` 0, `prio_q` 0, `req_ready_o` 0 (no valid inputs).
- Latency: request accepted in cycle N appears on `valid_o` in cycle N+1.
- Throughput: 1 beat/cycle while `ready_i` is held high (simultaneous drain and load).
- Back-pressure: while `valid_q & ~ready_i`, `req_ready_o` is all zeros.
- Simultaneous `flush_i` and `ready_i`: the flush wins and the beat is dropped (downstream ignores it by contract).
- Reset asserted mid-transfer: output valid clears immediately (asynchronously); the in-flight beat is lost.

## Structure
- Shared package `iopmp_arb_pkg`: no typedefs needed beyond `cf_math_pkg::idx_width`. The wrap helper function `next_prio(idx, n)` lives there for reuse by the future multi-port checker.
- Sub-modules: two `lzc` instances (`WIDTH=NumReq`, `MODE=0`), masked and unmasked. No other sub-module. The output stage is inline flops.
- Expected size: about 150 RTL lines.

## Test plan
- Reset release, `req_valid_i=4'b0000` → `valid_o=0`, `req_ready_o=0`, `idx_o=0` held for 5 cycles.
- `req_valid_i=4'b1111` constant, `ready_i=1` → `req_ready_o` sequence 0001, 0010, 0100, 1000, 0001; `idx_o` one cycle later 0,1,2,3,0; one beat per cycle.
- `NumReq=3`, `req_valid_i=3'b101`, `ready_i=1` → grants 0,2,0,2; `prio_q` wraps from 2 to 0, never reaches 3.
- Beat from requester 1 with data 0xA5A5_0001 captured, then `ready_i=0` for 3 cycles with `req_valid_i=4'b1111` → `data_o`/`idx_o` stable at 0xA5A5_0001 / 1, `req_ready_o=0`. Raise `ready_i` → next grant goes to requester 2.
- `flush_i` pulsed while `valid_o=1` and `prio_q=3` → next cycle `valid_o=0`; a subsequent `req_valid_i=4'b1001` is granted to requester 0 first.
- Asynchronous `rst_ni` low mid-cycle with `valid_o=1` → `valid_o` drops before the next clock edge; after release, priority restarts at 0.
